// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   state_t         loader FSM state encoding (also exported for debug)
//   IMEM_DEPTH      default instruction memory depth in 32-bit words
//   IMEM_ADDR_W     default word-address width, log2(IMEM_DEPTH)
//   BYTES_PER_WORD  stream bytes packed into one memory word
package imem_loader_pkg;

  localparam int IMEM_DEPTH     = 8192;
  localparam int IMEM_ADDR_W    = 13;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSEMBLE = 2'd1,
    S_WRITE    = 2'd2,
    S_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: collects stream bytes into a big-endian 32-bit word.
// The first byte of a word ends up in [31:24], the fourth in [7:0].
// Ports:
//   clock, reset  clock and asynchronous active-high reset
//   clear         discard any partial word (takes priority over load)
//   load          accept din this cycle
//   din           stream byte
//   word          packed word (registered)
//   word_full     combinational: this load completes a word
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] count;

  // The counter wraps naturally after the last byte of a word, so no
  // explicit clear is needed between consecutive words.
  assign word_full = load && (count == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (load) begin
      word  <= {word[23:0], din};
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: write side of the single-cycle MIPS instruction memory.
// Takes a byte stream over a valid/ready handshake, packs big-endian words
// and writes them to word addresses 0..word_count-1. cpu_hold keeps the CPU
// in reset until the load has finished.
//
// Handshake: a byte transfers on a rising clock edge where byte_valid and
// byte_ready are both high; byte_ready depends on the registered state only,
// never on byte_valid, and the source may hold byte_valid/byte_data as long
// as it likes.
//
// Ports:
//   clock, reset    clock, asynchronous active-high reset
//   start           begin a load (honoured only in IDLE or DONE)
//   word_count      number of program words, latched on an accepted start
//   byte_valid/byte_data/byte_ready   byte stream handshake
//   mem_we/mem_addr/mem_wdata         instruction memory write port
//   busy, done, error, cpu_hold       status
//   dbg_state       current FSM state, for observation only
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a 4-byte
// trailer after the data words equal to the mod-2^32 sum of the data words;
// a mismatch sets error (done still asserts).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output state_t            dbg_state
);

  state_t       state, state_next;
  logic [ADDR_W:0] index, wc;
  logic         start_ok, accept, last_word, overflow, trailer_bad;
  logic [31:0]  packed_word;
  logic         word_full;

  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign accept    = byte_valid && byte_ready;
  assign overflow  = word_count > (ADDR_W + 1)'(DEPTH);
  assign last_word = (index == (wc - (ADDR_W + 1)'(1)));

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic        trailer;
  logic [31:0] sum;
  // The trailer is compared including the byte completing it this cycle.
  assign trailer_bad = trailer && word_full && ({packed_word[23:0], byte_data} != sum);
`else
  assign trailer_bad = 1'b0;
`endif

  byte_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_ok),
    .load      (accept),
    .din       (byte_data),
    .word      (packed_word),
    .word_full (word_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (overflow) begin
            state_next = S_DONE;
          end else if (word_count == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_next = S_ASSEMBLE;  // still expects an all-zero trailer
`else
            state_next = S_DONE;
`endif
          end else begin
            state_next = S_ASSEMBLE;
          end
        end
      end
      S_ASSEMBLE: begin
        if (word_full) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = trailer ? S_DONE : S_WRITE;
`else
          state_next = S_WRITE;
`endif
        end
      end
      S_WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = S_ASSEMBLE;
`else
          state_next = S_DONE;
`endif
        end else begin
          state_next = S_ASSEMBLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state and registers only.
  always_comb begin
    byte_ready = (state == S_ASSEMBLE);
    mem_we     = (state == S_WRITE);
    busy       = (state == S_ASSEMBLE) || (state == S_WRITE);
    done       = (state == S_DONE);
    cpu_hold   = (state != S_DONE);
    mem_addr   = index[ADDR_W-1:0];
    mem_wdata  = packed_word;
    dbg_state  = state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index <= '0;
      wc    <= '0;
      error <= 1'b0;
    end else begin
      if (start_ok) begin
        index <= '0;
        wc    <= word_count;
        error <= overflow;
      end else begin
        if ((state == S_WRITE) && !last_word) index <= index + (ADDR_W + 1)'(1);
        if (trailer_bad) error <= 1'b1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trailer <= 1'b0;
      sum     <= '0;
    end else if (start_ok) begin
      trailer <= (word_count == '0);
      sum     <= '0;
    end else if (state == S_WRITE) begin
      sum <= sum + packed_word;
      if (last_word) trailer <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH  = 8192;
  localparam int ADDR_W = 13;
  localparam int EW     = ADDR_W + 32;

  logic              clock, reset, start, byte_valid;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        byte_data;
  logic              byte_ready, mem_we, busy, done, error, cpu_hold;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  state_t            dbg_state;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int check_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];

  always @(negedge clock) if (mem_we) got_q.push_back({mem_addr, mem_wdata});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic compare_writes(input string tag);
    check($sformatf("%s_write_count", tag), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_write%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_word(input logic [7:0] d[$], input int i);
    return (32'(d[4*i]) << 24) + (32'(d[4*i+1]) << 16) + (32'(d[4*i+2]) << 8) + 32'(d[4*i+3]);
  endfunction

  function automatic logic [31:0] model_sum(input logic [7:0] d[$], input int n);
    logic [31:0] s = 0;
    for (int i = 0; i < n; i++) s = s + model_word(d, i);
    return s;
  endfunction

  // ---------------- driver ----------------
  // One complete load: start pulse, byte feed (optionally with random gaps),
  // bounded wait for done, then status and write-list comparison.
  task automatic run_load(input int wc, input logic [7:0] data[$], input logic [31:0] trailer,
                          input bit rand_valid, input string tag);
    logic [7:0] stream[$];
    bit exp_err, exp_busy, chk;
    int idx, c;
    chk = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk = 1'b1;
`endif
    stream = data;
    exp_q.delete();
    got_q.delete();
    exp_err = (wc > DEPTH);
    if (wc <= DEPTH) begin
      for (int i = 0; i < wc; i++) exp_q.push_back({ADDR_W'(i), model_word(data, i)});
      if (chk) begin
        for (int b = 3; b >= 0; b--) stream.push_back(trailer[8*b +: 8]);
        exp_err = (trailer != model_sum(data, wc));
      end
    end
    exp_busy = (wc <= DEPTH) && (wc > 0 || chk);

    start = 1'b1;
    word_count = (ADDR_W + 1)'(wc);
    @(negedge clock);
    start = 1'b0;
    check({tag, "_busy_after_start"}, 64'(busy), 64'(exp_busy));
    check({tag, "_ready_after_start"}, 64'(byte_ready), 64'(exp_busy));
    check({tag, "_done_after_start"}, 64'(done), 64'(!exp_busy));
    check({tag, "_error_after_start"}, 64'(error), 64'(wc > DEPTH));

    idx = 0;
    c = 0;
    while (idx < stream.size() && c < 1000) begin
      byte_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = byte_valid ? stream[idx] : 8'($urandom);
      if (byte_valid && byte_ready) idx++;
      @(negedge clock);
      c++;
    end
    byte_valid = 1'b0;
    check({tag, "_bytes_consumed"}, 64'(idx), 64'(stream.size()));
    for (c = 0; c < 50 && !done; c++) @(negedge clock);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_cpu_hold_end"}, 64'(cpu_hold), 64'd0);
    check({tag, "_error"}, 64'(error), 64'(exp_err));
    compare_writes(tag);
  endtask

  // ---------------- per-cycle table for the backpressure trace ----------------
  typedef struct {
    logic valid;
    logic ready;
    logic we;
    logic busy;
    logic done;
    logic hold;
  } vec_t;
  vec_t tbl[11];

  initial begin
    logic [7:0] bq[$];
    logic [7:0] stream[$];
    logic [31:0] sum;
    int idx, wc;

    //            valid ready we busy done hold   (index = cycles after start edge)
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef IMEM_LOADER_CHECKSUM_EN
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif

    // ---- reset ----
    reset = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(negedge clock);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_busy_done_error", 64'({busy, done, error}), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    reset = 1'b0;
    @(negedge clock);

    // ---- basic load with byte_valid held high: cycle-exact trace ----
    bq = '{8'h20, 8'h08, 8'h01, 8'hF4, 8'h20, 8'h10, 8'h00, 8'h07};
    stream = bq;
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h40); stream.push_back(8'h18); stream.push_back(8'h01); stream.push_back(8'hFB);
`endif
    exp_q.delete();
    got_q.delete();
    exp_q.push_back({13'd0, 32'h200801F4});
    exp_q.push_back({13'd1, 32'h20100007});
    start = 1'b1; word_count = 14'd2;
    @(negedge clock);
    start = 1'b0;
    idx = 0;
    for (int j = 0; j < 11; j++) begin
      check($sformatf("bp_ready_c%0d", j), 64'(byte_ready), 64'(tbl[j].ready));
      check($sformatf("bp_we_c%0d", j), 64'(mem_we), 64'(tbl[j].we));
      check($sformatf("bp_status_c%0d", j), 64'({busy, done, cpu_hold}),
            64'({tbl[j].busy, tbl[j].done, tbl[j].hold}));
      byte_valid = tbl[j].valid;
      byte_data  = (idx < stream.size()) ? stream[idx] : 8'hAA;
      if (byte_valid && byte_ready && idx < stream.size()) idx++;
      @(negedge clock);
    end
    for (int c = 0; c < 20 && idx < stream.size(); c++) begin
      byte_data = stream[idx];
      if (byte_ready) idx++;
      @(negedge clock);
    end
    byte_valid = 1'b0;
    for (int c = 0; c < 20 && !done; c++) @(negedge clock);
    check("bp_bytes_consumed", 64'(idx), 64'(stream.size()));
    check("bp_done", 64'(done), 64'd1);
    check("bp_error", 64'(error), 64'd0);
    compare_writes("bp");

    // ---- same program with random gaps on byte_valid ----
    run_load(2, bq, 32'h401801FB, 1'b1, "basic");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // ---- wrong trailer ----
    run_load(2, bq, 32'h00000000, 1'b1, "cksum_bad");
`endif

    // ---- reload from DONE with one word ----
    run_load(1, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 32'hDEADBEEF, 1'b1, "reload");

    // ---- boundaries ----
    bq.delete();
    run_load(0, bq, 32'h00000000, 1'b0, "wc_zero");
    run_load(DEPTH + 1, bq, 32'h00000000, 1'b0, "wc_over");

    // ---- random programs against the model ----
    for (int r = 0; r < 6; r++) begin
      wc = $urandom_range(1, 5);
      bq.delete();
      for (int b = 0; b < 4 * wc; b++) bq.push_back(8'($urandom));
      sum = model_sum(bq, wc);
      if ($urandom_range(0, 3) == 0) sum = sum ^ 32'h0000_0100;
      run_load(wc, bq, sum, 1'b1, $sformatf("rand%0d", r));
    end

    // ---- reset mid-load after 2 of 4 bytes ----
    got_q.delete();
    start = 1'b1; word_count = 14'd1;
    @(negedge clock);
    start = 1'b0;
    idx = 0;
    for (int c = 0; c < 20 && idx < 2; c++) begin
      byte_valid = 1'b1;
      byte_data  = 8'h11 + 8'(idx);
      if (byte_ready) idx++;
      @(negedge clock);
    end
    byte_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_bytes_sent", 64'(idx), 64'd2);
    check("mid_rst_outputs", 64'({byte_ready, mem_we, busy, done, error, cpu_hold}), 64'b000001);
    check("mid_rst_addr_data", 64'({mem_addr, mem_wdata}), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    byte_valid = 1'b1;
    byte_data = 8'h55;
    repeat (8) @(negedge clock);
    byte_valid = 1'b0;
    check("mid_rst_no_writes", 64'(got_q.size()), 64'd0);
    check("mid_rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("mid_rst_idle", 64'({dbg_state, byte_ready}), 64'({S_IDLE, 1'b0}));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the single-cycle MIPS instruction memory: the write side of the instruction store. Accepts a byte stream from a host or UART front end over a valid/ready handshake, packs bytes into big-endian 32-bit words and writes them sequentially, from word address 0, into the instruction memory write port. Holds the CPU in reset until the load completes, so the fetch side never reads a partially loaded program.

## Interface
Parameters:
- DEPTH, 8192: instruction memory depth in 32-bit words.
- ADDR_W, 13: word-address width, equal to log2(DEPTH).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- word_count  in  ADDR_W+1  number of program words; latched on the accepted start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address; the memory indexes by word, not by pc.
- mem_wdata  out  32  word to write.
- busy  out  1  load in progress.
- done  out  1  sticky load-complete flag; cleared by the next accepted start.
- error  out  1  sticky error flag; cleared by the next accepted start.
- cpu_hold  out  1  CPU reset request; high in every state except DONE.

## Operation
- States: IDLE, ASSEMBLE, WRITE, DONE.
- IDLE, on start:
  - word_count == 0 -> DONE.
  - word_count > DEPTH -> error=1, go to DONE, no writes.
  - Otherwise -> ASSEMBLE with word index 0 and byte count 0.
- ASSEMBLE: byte_ready=1. A byte is accepted when byte_valid and byte_ready are both high. Bytes are big-endian: the first byte goes to [31:24] and the fourth to [7:0]. On the 4th byte -> WRITE.
- WRITE: byte_ready=0. Drives mem_we=1, mem_addr=index, mem_wdata=packed word. Next state:
  - index == word_count-1 -> DONE (or checksum phase if enabled).
  - Otherwise index+1 -> ASSEMBLE.
- DONE: done=1, cpu_hold=0. A new start restarts the load exactly as from IDLE and clears done and error.
- start in ASSEMBLE or WRITE is ignored.
- Bytes presented outside ASSEMBLE are not consumed (byte_ready=0).
- Index arithmetic is unsigned ADDR_W+1 bits. Index never wraps because word_count is bounded by DEPTH.

## Timing
- Reset values: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_hold=1.
- All outputs are registered or decoded from the registered state only. There is no combinational path from byte_valid to byte_ready.
- Accepted start at cycle N: busy=1 and byte_ready=1 at N+1.
- 4th byte accepted at cycle N: mem_we=1 at N+1, byte_ready=1 again at N+2. Peak rate is 4 bytes per 5 cycles.
- Last write at cycle N: done=1, busy=0, cpu_hold=0 at N+1.
- Reset asserted mid-load: immediate return to the reset values; the partial word is discarded; no further mem_we. Memory contents already written are left as is.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last data word, the loader stays in ASSEMBLE for one extra 4-byte trailer word with no memory write.
  - The trailer is compared with the mod-2^32 sum of all data words.
  - Mismatch sets error=1. done still asserts.
  - word_count==0 expects the trailer 0x00000000.
- Undefined: no trailer. The word_count overflow is the only error source.

## Structure
- Package imem_loader_pkg: state enum type, DEPTH/ADDR_W defaults, BYTES_PER_WORD=4.
- Sub-module byte_packer: 32-bit shift register plus 2-bit byte counter, with clear and word_full outputs. It is reused for the checksum trailer.
- imem_loader contains the FSM, index counter, checksum accumulator and output registers.

## Test plan
- Reset mid-load:
  - Stimulus: reset asserted after 2 of 4 bytes.
  - Required: no mem_we, cpu_hold=1, all outputs at reset values.
- Basic load:
  - Stimulus: word_count=2, bytes 20 08 01 F4 20 10 00 07.
  - Required: writes addr0=0x200801F4, then addr1=0x20100007; done=1, cpu_hold=0, error=0.
- Backpressure:
  - Stimulus: byte_valid held high continuously.
  - Required: byte_ready=0 during each WRITE cycle, no byte dropped or duplicated; 8 bytes take exactly 10 cycles after start.
- Boundary:
  - Stimulus: word_count=0, then word_count=8193.
  - Required: word_count=0 gives done with no writes; word_count=8193 gives error=1 and done with no writes.
- Checksum (macro on):
  - Stimulus: the 2 words above plus trailer 0x401801FB.
  - Required: error=0.
  - Stimulus: trailer 0x00000000.
  - Required: error=1, done=1.
- Reload:
  - Stimulus: start in DONE with word_count=1.
  - Required: done clears next cycle, new word written at addr0.
